// File: rtl/multi_edge_detector_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Mode encoding per channel plus the debounce counter sizing rule.
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    function automatic int deb_cnt_w(input int debounce);
        return $clog2(debounce) + 1;
    endfunction

    function automatic logic mode_gate(input edge_mode_t mode, input logic rise, input logic fall);
        logic ev;
        case (mode)
            EDGE_NONE: ev = 1'b0;
            EDGE_RISE: ev = rise;
            EDGE_FALL: ev = fall;
            EDGE_BOTH: ev = rise | fall;
            default:   ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/multi_edge_detector_if.sv
// Channel bus of the multi-channel edge detector: raw inputs and controls
// from the master, filtered levels, pulses, status and counts from the slave.
interface multi_edge_detector_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]       a_i;
    logic [2*N_CH-1:0]     mode_i;
    logic [N_CH-1:0]       irq_en_i;
    logic [N_CH-1:0]       clear_i;
    logic [N_CH-1:0]       level_o;
    logic [N_CH-1:0]       rise_o;
    logic [N_CH-1:0]       fall_o;
    logic [N_CH-1:0]       event_o;
    logic [N_CH-1:0]       status_o;
    logic [N_CH*CNT_W-1:0] count_o;
    logic                  irq_o;

    modport master (
        output a_i, mode_i, irq_en_i, clear_i,
        input  level_o, rise_o, fall_o, event_o, status_o, count_o, irq_o
    );

    modport slave (
        input  a_i, mode_i, irq_en_i, clear_i,
        output level_o, rise_o, fall_o, event_o, status_o, count_o, irq_o
    );
endinterface

// File: rtl/multi_edge_detector_debounce_filter.sv
// Single channel front end: optional synchroniser, debounce filter and
// rise/fall pulse generation from the registered debounced level.
module debounce_filter
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int            CW      = deb_cnt_w(DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic          s_s;
    logic          lvl_r;
    logic          lvl_d_r;
    logic [CW-1:0] cnt_r;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign s_s = a;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_r;

            // Synchroniser chain; newest sample enters at bit 0.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_r <= '0;
                end else begin
                    sync_r <= SYNC_STAGES'({sync_r, a});
                end
            end

            assign s_s = sync_r[SYNC_STAGES-1];
        end
    endgenerate

    // A new level is accepted only after DEBOUNCE consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_r   <= 1'b0;
            lvl_d_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            lvl_d_r <= lvl_r;
            if (s_s == lvl_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_MAX) begin
                lvl_r <= s_s;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign level = lvl_r;
    assign rise  = lvl_r & ~lvl_d_r;
    assign fall  = ~lvl_r & lvl_d_r;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel debounce front end, mode gating,
// sticky status, saturating event counters and a combined interrupt.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input logic                 clk,
    input logic                 reset,
    multi_edge_detector_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    logic [N_CH-1:0] status_s;

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            logic             level_s;
            logic             rise_s;
            logic             fall_s;
            logic             ev_s;
            logic             status_r;
            logic [CNT_W-1:0] cnt_r;
            logic [CNT_W-1:0] cnt_nxt_s;

            debounce_filter #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEBOUNCE    (DEBOUNCE)
            ) u_filt (
                .clk   (clk),
                .reset (reset),
                .a     (bus.a_i[c]),
                .level (level_s),
                .rise  (rise_s),
                .fall  (fall_s)
            );

            assign ev_s = mode_gate(edge_mode_t'(bus.mode_i[2*c +: 2]), rise_s, fall_s);

            // A clear coinciding with an event restarts the count at one.
            always_comb begin
                cnt_nxt_s = cnt_r;
                if (bus.clear_i[c]) begin
                    cnt_nxt_s = ev_s ? CNT_W'(1) : '0;
                end else if (ev_s && (cnt_r != CNT_SAT)) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end

            // Sticky status (set wins over clear) and counter registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    status_r <= 1'b0;
                    cnt_r    <= '0;
                end else begin
                    status_r <= ev_s | (status_r & ~bus.clear_i[c]);
                    cnt_r    <= cnt_nxt_s;
                end
            end

            assign bus.level_o[c]                  = level_s;
            assign bus.rise_o[c]                   = rise_s;
            assign bus.fall_o[c]                   = fall_s;
            assign bus.event_o[c]                  = ev_s;
            assign bus.count_o[c*CNT_W +: CNT_W]   = cnt_r;
            assign status_s[c]                     = status_r;
        end
    endgenerate

    assign bus.status_o = status_s;
    assign bus.irq_o    = |(status_s & bus.irq_en_i);

endmodule

// File: tb/tb_multi_edge_detector.sv
// Randomised and directed checks of multi_edge_detector against a
// sample-window model of debounce, gating, status and counting.
module tb_multi_edge_detector;
    import edge_det_pkg::*;

    localparam int N_CH    = 4;
    localparam int SYNC    = 2;
    localparam int DEB     = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int WIN     = (1 << DEB) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_edge_detector_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus();

    multi_edge_detector #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Model: raw sample history, synced-sample window, level and its last value.
    int a_hist  [N_CH];
    int s_hist  [N_CH];
    bit m_lvl   [N_CH];
    bit m_lvl_d [N_CH];
    bit m_stat  [N_CH];
    int m_cnt   [N_CH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < N_CH; c++) begin
            a_hist[c] = 0; s_hist[c] = 0;
            m_lvl[c] = 1'b0; m_lvl_d[c] = 1'b0; m_stat[c] = 1'b0; m_cnt[c] = 0;
        end
    endfunction

    function automatic bit m_event(int c);
        bit r, f;
        logic [1:0] md;
        r  = m_lvl[c] & ~m_lvl_d[c];
        f  = ~m_lvl[c] & m_lvl_d[c];
        md = bus.mode_i[2*c +: 2];
        return (md[0] & r) | (md[1] & f);
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < N_CH; c++) begin
            bit ev, clr, s;
            int want;
            ev  = m_event(c);
            clr = bus.clear_i[c];
            if (clr) m_cnt[c] = ev ? 1 : 0;
            else if (ev) m_cnt[c] = (m_cnt[c] < CNT_MAX) ? m_cnt[c] + 1 : CNT_MAX;
            m_stat[c] = ev | (m_stat[c] & ~clr);
            a_hist[c] = ((a_hist[c] << 1) | int'(bus.a_i[c])) & 255;
            s = bit'((a_hist[c] >> SYNC) & 1);
            s_hist[c] = ((s_hist[c] << 1) | int'(s)) & WIN;
            want = m_lvl[c] ? 0 : WIN;
            m_lvl_d[c] = m_lvl[c];
            if (s_hist[c] == want) m_lvl[c] = ~m_lvl[c];
        end
    endfunction

    task automatic compare_all();
        logic [N_CH-1:0] e_lvl, e_rise, e_fall, e_ev, e_stat;
        logic [N_CH*CNT_W-1:0] e_cnt;
        logic [CNT_W-1:0] cv;
        for (int c = 0; c < N_CH; c++) begin
            e_lvl[c]  = m_lvl[c];
            e_rise[c] = m_lvl[c] & ~m_lvl_d[c];
            e_fall[c] = ~m_lvl[c] & m_lvl_d[c];
            e_ev[c]   = m_event(c);
            e_stat[c] = m_stat[c];
            cv = CNT_W'(m_cnt[c]);
            e_cnt[c*CNT_W +: CNT_W] = cv;
        end
        check("level",  64'(bus.level_o),  64'(e_lvl));
        check("rise",   64'(bus.rise_o),   64'(e_rise));
        check("fall",   64'(bus.fall_o),   64'(e_fall));
        check("event",  64'(bus.event_o),  64'(e_ev));
        check("status", 64'(bus.status_o), 64'(e_stat));
        check("count",  64'(bus.count_o),  64'(e_cnt));
        check("irq",    64'(bus.irq_o),    64'(|(e_stat & bus.irq_en_i)));
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic step();
        #1 compare_all();
        @(posedge clk);
        if (reset) model_clear();
        else model_edge();
        @(negedge clk);
    endtask

    task automatic set_mode(input int c, input logic [1:0] m);
        bus.mode_i[2*c +: 2] = m;
    endtask

    initial begin
        int first, width, ev_w, rise_n, ev_on_rise;
        reset = 1'b1;
        bus.a_i = '0; bus.mode_i = '0; bus.irq_en_i = '0; bus.clear_i = '0;
        model_clear();
        @(negedge clk);
        step(); step();
        check("reset_level", 64'(bus.level_o), 64'd0);
        check("reset_count", 64'(bus.count_o), 64'd0);
        reset = 1'b0;
        step();

        // ch0 rise with mode 01: latency and pulse width
        set_mode(0, 2'b01);
        bus.a_i[0] = 1'b1;
        first = 0; width = 0; ev_w = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.rise_o[0]) begin if (first == 0) first = i; width++; end
            if (bus.event_o[0]) ev_w++;
        end
        check("rise_latency", 64'(first), 64'd6);
        check("rise_width", 64'(width), 64'd1);
        check("event_width", 64'(ev_w), 64'd1);
        check("status0", 64'(bus.status_o[0]), 64'd1);
        check("count0", 64'(bus.count_o[1:0]), 64'd1);

        // ch1 three-cycle glitch is filtered out
        set_mode(1, 2'b11);
        width = 0;
        bus.a_i[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); width += int'(bus.level_o[1] | bus.rise_o[1] | bus.fall_o[1]); end
        bus.a_i[1] = 1'b0;
        for (int i = 0; i < 15; i++) begin step(); width += int'(bus.level_o[1] | bus.rise_o[1] | bus.fall_o[1]); end
        check("glitch_activity", 64'(width), 64'd0);
        check("glitch_count", 64'(bus.count_o[3:2]), 64'd0);

        // ch2 fall-only then both
        for (int pass = 0; pass < 2; pass++) begin
            set_mode(2, pass == 0 ? 2'b10 : 2'b11);
            if (pass == 1) begin bus.clear_i[2] = 1'b1; step(); bus.clear_i[2] = 1'b0; end
            rise_n = 0; ev_w = 0; ev_on_rise = 0;
            for (int i = 0; i < 20; i++) begin
                bus.a_i[2] = (i < 10);
                step();
                rise_n += int'(bus.rise_o[2]);
                ev_w += int'(bus.event_o[2]);
                ev_on_rise += int'(bus.event_o[2] & bus.rise_o[2]);
            end
            check("ch2_rises", 64'(rise_n), 64'd1);
            check("ch2_events", 64'(ev_w), pass == 0 ? 64'd1 : 64'd2);
            check("ch2_event_on_rise", 64'(ev_on_rise), pass == 0 ? 64'd0 : 64'd1);
            check("ch2_count", 64'(bus.count_o[5:4]), pass == 0 ? 64'd1 : 64'd2);
        end

        // ch3 saturation, then clear coincident with an event
        set_mode(3, 2'b01);
        for (int k = 0; k < 5; k++) begin
            bus.a_i[3] = 1'b1; for (int i = 0; i < 8; i++) step();
            bus.a_i[3] = 1'b0; for (int i = 0; i < 8; i++) step();
        end
        check("ch3_saturated", 64'(bus.count_o[7:6]), 64'd3);
        bus.a_i[3] = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("ch3_sixth_rise", 64'(bus.event_o[3]), 64'd1);
        bus.clear_i[3] = 1'b1; step(); bus.clear_i[3] = 1'b0;
        check("ch3_clear_event_count", 64'(bus.count_o[7:6]), 64'd1);
        check("ch3_clear_event_status", 64'(bus.status_o[3]), 64'd1);

        // interrupt masking
        check("irq_masked", 64'(bus.irq_o), 64'd0);
        bus.irq_en_i = 4'b0001;
        #1 check("irq_enable_same_cycle", 64'(bus.irq_o), 64'd1);
        bus.clear_i[0] = 1'b1; step(); bus.clear_i[0] = 1'b0;
        check("irq_after_clear", 64'(bus.irq_o), 64'd0);

        // reset in the middle of a debounce
        bus.a_i[0] = 1'b0;
        for (int i = 0; i < 12; i++) step();
        bus.a_i[0] = 1'b1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1; model_clear();
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_outputs", 64'({bus.level_o, bus.rise_o, bus.status_o, bus.count_o, bus.irq_o}), 64'd0);
        end
        reset = 1'b0;
        first = 0; width = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (bus.rise_o[0]) begin if (first == 0) first = i; width++; end
        end
        check("rst_rise_latency", 64'(first), 64'd6);
        check("rst_rise_width", 64'(width), 64'd1);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 7) == 0) bus.a_i[c] = ~bus.a_i[c];
                bus.clear_i[c] = ($urandom_range(0, 11) == 0);
            end
            if ($urandom_range(0, 31) == 0) bus.mode_i = 8'($urandom);
            if ($urandom_range(0, 15) == 0) bus.irq_en_i = 4'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1; model_clear(); step(); reset = 1'b0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised multi-channel successor to the single-bit edge detector.
- Each channel provides: optional input synchroniser, debounce filter, rise/fall detection, per-channel mode select, sticky status, saturating event counter, and a combined interrupt.
- Sits between raw asynchronous inputs (buttons, external strobes) and control logic that consumes clean single-cycle event pulses.

Parameters:
- N_CH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (0 = bypass, input already synchronous).
- DEBOUNCE, 4, consecutive cycles a new level must persist before acceptance (>=1; 1 = no filtering beyond one register).
- CNT_W, 8, width of each per-channel event counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- a_i  input  N_CH  raw channel inputs.
- mode_i  input  2*N_CH  per-channel mode, channel i in bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both.
- irq_en_i  input  N_CH  per-channel interrupt enable.
- clear_i  input  N_CH  per-channel clear of status and counter (level, one cycle per clear).
- level_o  output  N_CH  debounced level.
- rise_o  output  N_CH  one-cycle pulse on accepted 0->1, independent of mode.
- fall_o  output  N_CH  one-cycle pulse on accepted 1->0, independent of mode.
- event_o  output  N_CH  rise/fall pulses gated by mode.
- status_o  output  N_CH  sticky event flags.
- count_o  output  N_CH*CNT_W  saturating event counts, channel i in bits [(i+1)*CNT_W-1:i*CNT_W].
- irq_o  output  1  OR over channels of (status_o & irq_en_i).

Behaviour:
- Reset (async, active-high): synchroniser flops, lvl, lvl_d, debounce counters, status and counters all go to 0.
  - Every output is 0 while reset is asserted.
  - A channel whose a_i is high at reset release produces one rise pulse after the normal latency. This is intended.
- Synchroniser: SYNC_STAGES flop chain; output s. With SYNC_STAGES=0, s = a_i combinationally.
- Debounce, per channel, with lvl (debounced level) and cnt of width clog2(DEBOUNCE)+1:
  - s == lvl: cnt <= 0.
  - s != lvl and cnt == DEBOUNCE-1: lvl <= s, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE cycles never changes lvl.
- Edge pulses: lvl_d <= lvl each cycle.
  - rise_o = lvl & ~lvl_d; fall_o = ~lvl & lvl_d. Both are pure functions of flops.
- Latency: a stable change on a_i produces a pulse on rise_o/fall_o exactly SYNC_STAGES+DEBOUNCE cycles after the first clock edge that samples it. The pulse is exactly 1 cycle wide.
- Mode gating: event_o = (mode[0] & rise_o) | (mode[1] & fall_o).
  - Gating is combinational; a mode change takes effect the same cycle.
  - Mode 00 suppresses event_o, status and counter updates, but not rise_o/fall_o.
- Status:
  - set on event_o; cleared on clear_i.
  - event and clear in the same cycle -> status = 1 (set wins).
- Counter:
  - +1 on event_o; saturates at 2^CNT_W-1, no wrap.
  - clear_i alone -> 0.
  - clear_i with event in the same cycle -> 1.
- irq_o: combinational OR of flopped status masked by irq_en_i.
  - Enabling irq_en_i while status is already set raises irq_o immediately.
- Channels are fully independent; simultaneous events on several channels are all captured.
- Reset mid-debounce discards the pending count; no pulse is generated for the interrupted transition unless the input is still different from 0 after reset.

Decomposition:
- Package edge_det_pkg:
  - typedef enum logic [1:0] edge_mode_t {EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH}.
  - helper function for the debounce counter width.
- Sub-module debounce_filter (single channel: synchroniser + debounce + lvl/lvl_d, outputs level/rise/fall).
  - Instantiated N_CH times in a generate loop.
  - Top level adds mode gating, status, counters and irq.

Test Plan:
- Defaults, a_i[0] 0->1 held 20 cycles, mode 01 -> rise_o[0] and event_o[0] pulse 1 cycle exactly 6 cycles after the first sampling edge; status_o[0]=1, count=1.
- a_i[1] 3-cycle high glitch, DEBOUNCE=4 -> no change on level_o/rise_o/fall_o, count stays 0.
- ch2 mode 10, apply full pulse (rise then fall) -> rise_o pulses but event_o only on the fall; count=1. Repeat with mode 11 -> count=2 per full pulse.
- CNT_W=2, 5 rising events on ch3 mode 01 -> count_o saturates at 3. Then clear_i coincident with a 6th event -> count=1, status=1.
- irq_en_i=0 with status set -> irq_o=0. Set irq_en_i[0]=1 -> irq_o=1 same cycle. clear_i[0] -> irq_o=0 next cycle.
- Assert reset mid-debounce while a_i=1 and release -> all outputs 0 during reset; exactly one rise pulse SYNC_STAGES+DEBOUNCE cycles after release.
